// File: rtl/multicycle_controller.sv
// multicycle_controller: main control FSM of the multi-cycle RV32I core.
// Walks FETCH -> DECODE -> execute states per instruction and drives the
// datapath enables, mux selects and the ALU_op code for the ALU decoder.
// Optional feature macro: ILLEGAL_TRAP_EN. When it is defined, an unknown
// opcode parks the FSM in HALT and raises a sticky illegal_o flag until reset.
// When it is undefined, an unknown opcode behaves as a 2-cycle NOP.
module multicycle_controller #(
    parameter int STATE_W = 4
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [6:0] opcode_i,
    input  logic [2:0] f3_i,
    input  logic       zero_i,
    input  logic       neg_i,
    output logic       PC_write_o,
    output logic       IR_write_o,
    output logic       adr_src_o,
    output logic       mem_write_o,
    output logic       reg_write_o,
    output logic [1:0] ALU_src_A_o,
    output logic [1:0] ALU_src_B_o,
    output logic [1:0] ALU_op_o,
    output logic [1:0] result_src_o,
    output logic [2:0] imm_src_o
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic       illegal_o
`endif
);

    localparam logic [STATE_W-1:0] S_FETCH     = STATE_W'(0);
    localparam logic [STATE_W-1:0] S_DECODE    = STATE_W'(1);
    localparam logic [STATE_W-1:0] S_MEM_ADR   = STATE_W'(2);
    localparam logic [STATE_W-1:0] S_MEM_READ  = STATE_W'(3);
    localparam logic [STATE_W-1:0] S_MEM_WB    = STATE_W'(4);
    localparam logic [STATE_W-1:0] S_MEM_WRITE = STATE_W'(5);
    localparam logic [STATE_W-1:0] S_EXEC_R    = STATE_W'(6);
    localparam logic [STATE_W-1:0] S_EXEC_I    = STATE_W'(7);
    localparam logic [STATE_W-1:0] S_ALU_WB    = STATE_W'(8);
    localparam logic [STATE_W-1:0] S_BRANCH    = STATE_W'(9);
    localparam logic [STATE_W-1:0] S_JAL       = STATE_W'(10);
    localparam logic [STATE_W-1:0] S_JALR      = STATE_W'(11);
    localparam logic [STATE_W-1:0] S_LUI       = STATE_W'(12);
    localparam logic [STATE_W-1:0] S_HALT      = STATE_W'(13);

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BR   = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;
    localparam logic [6:0] OP_JALR = 7'b1100111;
    localparam logic [6:0] OP_LUI  = 7'b0110111;

    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_J = 3'b011;
    localparam logic [2:0] IMM_U = 3'b100;

    logic [STATE_W-1:0] state_q, state_d;

    // Raw Moore outputs before reset gating
    logic       pc_write_c, ir_write_c, adr_src_c, mem_write_c, reg_write_c;
    logic [1:0] src_a_c, src_b_c, alu_op_c, result_src_c;
    logic [2:0] imm_src_c;
    logic       br_taken;

    // Branch condition; evaluated combinationally so the decision uses this cycle's flags
    always_comb begin
        case (f3_i)
            3'b000:  br_taken = zero_i;
            3'b001:  br_taken = ~zero_i;
            3'b100:  br_taken = neg_i;
            3'b101:  br_taken = ~neg_i;
            default: br_taken = 1'b0;
        endcase
    end

    // State register; reset always lands in FETCH
    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_FETCH;
        else       state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: begin
                case (opcode_i)
                    OP_LW, OP_SW: state_d = S_MEM_ADR;
                    OP_R:         state_d = S_EXEC_R;
                    OP_I:         state_d = S_EXEC_I;
                    OP_BR:        state_d = S_BRANCH;
                    OP_JAL:       state_d = S_JAL;
                    OP_JALR:      state_d = S_JALR;
                    OP_LUI:       state_d = S_LUI;
`ifdef ILLEGAL_TRAP_EN
                    default:      state_d = S_HALT;
`else
                    default:      state_d = S_FETCH;
`endif
                endcase
            end
            S_MEM_ADR:   state_d = (opcode_i == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
            S_MEM_READ:  state_d = S_MEM_WB;
            S_MEM_WB:    state_d = S_FETCH;
            S_MEM_WRITE: state_d = S_FETCH;
            S_EXEC_R:    state_d = S_ALU_WB;
            S_EXEC_I:    state_d = S_ALU_WB;
            S_ALU_WB:    state_d = S_FETCH;
            S_BRANCH:    state_d = S_FETCH;
            S_JAL:       state_d = S_ALU_WB;
            // JALR loads the target, then reuses JAL to rewrite it and form the link
            S_JALR:      state_d = S_JAL;
            S_LUI:       state_d = S_FETCH;
            S_HALT:      state_d = S_HALT;
            default:     state_d = S_FETCH;
        endcase
    end

    // Moore output decode; unused selects held at 0
    always_comb begin
        pc_write_c   = 1'b0;
        ir_write_c   = 1'b0;
        adr_src_c    = 1'b0;
        mem_write_c  = 1'b0;
        reg_write_c  = 1'b0;
        src_a_c      = 2'b00;
        src_b_c      = 2'b00;
        alu_op_c     = 2'b00;
        result_src_c = 2'b00;
        imm_src_c    = IMM_I;
        case (state_q)
            S_FETCH: begin
                ir_write_c   = 1'b1;
                pc_write_c   = 1'b1;
                src_b_c      = 2'b10;
                result_src_c = 2'b10;
            end
            S_DECODE: begin
                src_a_c   = 2'b01;
                src_b_c   = 2'b01;
                imm_src_c = (opcode_i == OP_JAL) ? IMM_J : IMM_B;
            end
            S_MEM_ADR: begin
                src_a_c   = 2'b10;
                src_b_c   = 2'b01;
                imm_src_c = (opcode_i == OP_SW) ? IMM_S : IMM_I;
            end
            S_MEM_READ: adr_src_c = 1'b1;
            S_MEM_WB: begin
                result_src_c = 2'b01;
                reg_write_c  = 1'b1;
            end
            S_MEM_WRITE: begin
                adr_src_c   = 1'b1;
                mem_write_c = 1'b1;
            end
            S_EXEC_R: begin
                src_a_c  = 2'b10;
                alu_op_c = 2'b10;
            end
            S_EXEC_I: begin
                src_a_c  = 2'b10;
                src_b_c  = 2'b01;
                alu_op_c = 2'b11;
            end
            S_ALU_WB: reg_write_c = 1'b1;
            S_BRANCH: begin
                src_a_c    = 2'b10;
                alu_op_c   = 2'b01;
                pc_write_c = br_taken;
            end
            S_JAL: begin
                // ALUOut still holds the target computed in DECODE (or JALR)
                pc_write_c = 1'b1;
                src_a_c    = 2'b01;
                src_b_c    = 2'b10;
            end
            S_JALR: begin
                src_a_c      = 2'b10;
                src_b_c      = 2'b01;
                result_src_c = 2'b10;
                pc_write_c   = 1'b1;
            end
            S_LUI: begin
                imm_src_c    = IMM_U;
                result_src_c = 2'b11;
                reg_write_c  = 1'b1;
            end
            default: ;
        endcase
    end

    // Everything is forced low while rst is asserted, so a mid-instruction reset cannot strobe
    assign PC_write_o   = pc_write_c  & ~rst_i;
    assign IR_write_o   = ir_write_c  & ~rst_i;
    assign adr_src_o    = adr_src_c   & ~rst_i;
    assign mem_write_o  = mem_write_c & ~rst_i;
    assign reg_write_o  = reg_write_c & ~rst_i;
    assign ALU_src_A_o  = rst_i ? 2'b00 : src_a_c;
    assign ALU_src_B_o  = rst_i ? 2'b00 : src_b_c;
    assign ALU_op_o     = rst_i ? 2'b00 : alu_op_c;
    assign result_src_o = rst_i ? 2'b00 : result_src_c;
    assign imm_src_o    = rst_i ? 3'b000 : imm_src_c;
`ifdef ILLEGAL_TRAP_EN
    // HALT is only left through reset, so the flag is sticky by construction
    assign illegal_o    = (state_q == S_HALT) & ~rst_i;
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks each instruction class
// through its states and checks the full output word in every cycle.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] f3;
    logic       zero, neg;
    logic       PC_write, IR_write, adr_src, mem_write, reg_write;
    logic [1:0] src_a, src_b, alu_op, result_src;
    logic [2:0] imm_src;
`ifdef ILLEGAL_TRAP_EN
    logic       illegal;
`endif

    int total = 0;
    int bad   = 0;

    multicycle_controller #(.STATE_W(4)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .opcode_i     (opcode),
        .f3_i         (f3),
        .zero_i       (zero),
        .neg_i        (neg),
        .PC_write_o   (PC_write),
        .IR_write_o   (IR_write),
        .adr_src_o    (adr_src),
        .mem_write_o  (mem_write),
        .reg_write_o  (reg_write),
        .ALU_src_A_o  (src_a),
        .ALU_src_B_o  (src_b),
        .ALU_op_o     (alu_op),
        .result_src_o (result_src),
        .imm_src_o    (imm_src)
`ifdef ILLEGAL_TRAP_EN
        ,
        .illegal_o    (illegal)
`endif
    );

    always #5 clk = ~clk;

    // {PC_write, IR_write, adr_src, mem_write, reg_write, A, B, op, result_src, imm_src}
    logic [15:0] obs;
    assign obs = {PC_write, IR_write, adr_src, mem_write, reg_write,
                  src_a, src_b, alu_op, result_src, imm_src};

    function automatic logic [15:0] mk(input logic pcw, input logic irw, input logic adr,
                                       input logic mw, input logic rw, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] op,
                                       input logic [1:0] rs, input logic [2:0] imm);
        return {pcw, irw, adr, mw, rw, a, b, op, rs, imm};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic o, input logic e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, o, e);
        end
    endtask

    logic [15:0] E_FETCH, E_DEC_B, E_DEC_J, E_MADR_LW, E_MADR_SW, E_MREAD, E_MWB,
                 E_MWRITE, E_EXR, E_EXI, E_ALUWB, E_BR_NT, E_BR_T, E_JAL, E_JALR,
                 E_LUI, E_ZERO;

    initial begin
        E_FETCH   = mk(1,1,0,0,0,2'b00,2'b10,2'b00,2'b10,3'b000);
        E_DEC_B   = mk(0,0,0,0,0,2'b01,2'b01,2'b00,2'b00,3'b010);
        E_DEC_J   = mk(0,0,0,0,0,2'b01,2'b01,2'b00,2'b00,3'b011);
        E_MADR_LW = mk(0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,3'b000);
        E_MADR_SW = mk(0,0,0,0,0,2'b10,2'b01,2'b00,2'b00,3'b001);
        E_MREAD   = mk(0,0,1,0,0,2'b00,2'b00,2'b00,2'b00,3'b000);
        E_MWB     = mk(0,0,0,0,1,2'b00,2'b00,2'b00,2'b01,3'b000);
        E_MWRITE  = mk(0,0,1,1,0,2'b00,2'b00,2'b00,2'b00,3'b000);
        E_EXR     = mk(0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,3'b000);
        E_EXI     = mk(0,0,0,0,0,2'b10,2'b01,2'b11,2'b00,3'b000);
        E_ALUWB   = mk(0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,3'b000);
        E_BR_NT   = mk(0,0,0,0,0,2'b10,2'b00,2'b01,2'b00,3'b000);
        E_BR_T    = mk(1,0,0,0,0,2'b10,2'b00,2'b01,2'b00,3'b000);
        E_JAL     = mk(1,0,0,0,0,2'b01,2'b10,2'b00,2'b00,3'b000);
        E_JALR    = mk(1,0,0,0,0,2'b10,2'b01,2'b00,2'b10,3'b000);
        E_LUI     = mk(0,0,0,0,1,2'b00,2'b00,2'b00,2'b11,3'b100);
        E_ZERO    = 16'h0000;

        rst = 1'b1; opcode = 7'b0100011; f3 = 3'b000; zero = 1'b0; neg = 1'b0;

        // Reset held 2 cycles: outputs all 0 throughout
        tick(); chk("rst_c0", E_ZERO);
        tick(); chk("rst_c1", E_ZERO);
        rst = 1'b0; #1;
        chk("fetch_after_rst", E_FETCH);

        // R-type: FETCH, DECODE, EXEC_R, ALU_WB, FETCH
        opcode = 7'b0110011;
        tick(); chk("r_decode", E_DEC_B);
        tick(); chk("r_exec", E_EXR);
        tick(); chk("r_aluwb", E_ALUWB);
        tick(); chk("r_fetch", E_FETCH);

        // I-type
        opcode = 7'b0010011;
        tick(); chk("i_decode", E_DEC_B);
        tick(); chk("i_exec", E_EXI);
        tick(); chk("i_aluwb", E_ALUWB);
        tick(); chk("i_fetch", E_FETCH);

        // lw: 5 cycles
        opcode = 7'b0000011;
        tick(); chk("lw_decode", E_DEC_B);
        tick(); chk("lw_memadr", E_MADR_LW);
        tick(); chk("lw_memread", E_MREAD);
        tick(); chk("lw_memwb", E_MWB);
        tick(); chk("lw_fetch", E_FETCH);

        // sw: mem_write exactly one cycle
        opcode = 7'b0100011;
        tick(); chk("sw_decode", E_DEC_B);
        tick(); chk("sw_memadr", E_MADR_SW);
        tick(); chk("sw_memwrite", E_MWRITE);
        tick(); chk("sw_fetch", E_FETCH);

        // beq taken
        opcode = 7'b1100011; f3 = 3'b000; zero = 1'b1;
        tick(); chk("beq_decode", E_DEC_B);
        tick(); chk("beq_taken", E_BR_T);
        tick(); chk("beq_fetch", E_FETCH);

        // bne with zero=1: not taken; then flip zero in-cycle to see the combinational path
        f3 = 3'b001; zero = 1'b1;
        tick(); chk("bne_decode", E_DEC_B);
        tick(); chk("bne_not_taken", E_BR_NT);
        zero = 1'b0; #1;
        chk1("bne_comb_pcw", PC_write, 1'b1);
        tick(); chk("bne_fetch", E_FETCH);

        // blt taken on neg
        f3 = 3'b100; zero = 1'b0; neg = 1'b1;
        tick(); tick(); chk("blt_taken", E_BR_T);
        tick(); chk("blt_fetch", E_FETCH);

        // bge with neg=0: taken
        f3 = 3'b101; neg = 1'b0;
        tick(); tick(); chk("bge_taken", E_BR_T);
        tick();

        // f3=010 never taken even with both flags set
        f3 = 3'b010; zero = 1'b1; neg = 1'b1;
        tick(); tick(); chk("f3_010_nt", E_BR_NT);
        tick(); chk("f3_010_fetch", E_FETCH);
        zero = 1'b0; neg = 1'b0; f3 = 3'b000;

        // jal: 4 cycles, J immediate in DECODE
        opcode = 7'b1101111;
        tick(); chk("jal_decode", E_DEC_J);
        tick(); chk("jal_jal", E_JAL);
        tick(); chk("jal_aluwb", E_ALUWB);
        tick(); chk("jal_fetch", E_FETCH);

        // jalr: JALR, JAL, ALU_WB
        opcode = 7'b1100111;
        tick(); chk("jalr_decode", E_DEC_B);
        tick(); chk("jalr_jalr", E_JALR);
        tick(); chk("jalr_jal", E_JAL);
        tick(); chk("jalr_aluwb", E_ALUWB);
        tick(); chk("jalr_fetch", E_FETCH);

        // lui: 3 cycles
        opcode = 7'b0110111;
        tick(); chk("lui_decode", E_DEC_B);
        tick(); chk("lui_lui", E_LUI);
        tick(); chk("lui_fetch", E_FETCH);

        // unknown opcode
        opcode = 7'b1111111;
        tick(); chk("ill_decode", E_DEC_B);
`ifdef ILLEGAL_TRAP_EN
        for (int i = 0; i < 10; i++) begin
            tick(); chk("ill_halt", E_ZERO);
            chk1("ill_flag", illegal, 1'b1);
        end
        rst = 1'b1;
        tick(); chk("ill_rst", E_ZERO);
        chk1("ill_flag_rst", illegal, 1'b0);
        rst = 1'b0; #1;
        chk("ill_fetch", E_FETCH);
        chk1("ill_flag_clr", illegal, 1'b0);
`else
        tick(); chk("ill_nop_fetch", E_FETCH);
`endif

        // Reset mid-instruction in MEM_WRITE: no strobe, then FETCH
        opcode = 7'b0100011;
        tick(); tick(); chk("sw2_memadr", E_MADR_SW);
        tick(); chk("sw2_memwrite", E_MWRITE);
        rst = 1'b1; #1;
        chk("rst_in_memwrite", E_ZERO);
        chk1("rst_memwrite_low", mem_write, 1'b0);
        tick(); chk("rst_hold", E_ZERO);
        rst = 1'b0; #1;
        chk("fetch_after_midrst", E_FETCH);
        tick(); chk("decode_after_midrst", E_DEC_B);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
